// File: rtl/roll_conditioner.sv
// Roll push-button front end: 2-FF synchroniser, debounce FSM with minimum roll time,
// one-cycle press/release pulses and a wrapping completed-roll counter.
module roll_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_ROLL_CYCLES = 8,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       roll,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] rolls
);

  localparam logic [CNT_W-1:0] DLAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MLOAD = CNT_W'(MIN_ROLL_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    ROLLING,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic             ff1;
  logic             sync_btn;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] mcnt;
  logic [CNT_W-1:0] mcnt_dec;

  assign mcnt_dec = (mcnt == '0) ? '0 : mcnt - CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ff1      <= 1'b0;
      sync_btn <= 1'b0;
    end else begin
      ff1      <= btn_raw;
      sync_btn <= ff1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dcnt          <= '0;
      mcnt          <= '0;
      roll          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      rolls         <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          roll <= 1'b0;
          if (sync_btn) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_btn) begin
            state <= IDLE;
          end else if (dcnt == DLAST) begin
            state       <= ROLLING;
            roll        <= 1'b1;
            press_pulse <= 1'b1;
            mcnt        <= MLOAD;
          end else begin
            dcnt <= dcnt + CNT_W'(1);
          end
        end
        ROLLING: begin
          mcnt <= mcnt_dec;
          if (!sync_btn) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end
        end
        RELEASE_WAIT: begin
          mcnt <= mcnt_dec;
          // A bounce back to pressed resumes rolling without reloading the minimum timer.
          if (sync_btn) begin
            state <= ROLLING;
            dcnt  <= '0;
          end else if (dcnt == DLAST) begin
            if (mcnt == '0) begin
              state         <= IDLE;
              roll          <= 1'b0;
              release_pulse <= 1'b1;
              rolls         <= rolls + 8'd1;
            end
          end else begin
            dcnt <= dcnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roll_conditioner.sv
// Directed bench for roll_conditioner at default parameters; per-edge logs of the outputs
// are reduced to rise/fall edges and pulse counts and compared against hand-worked values.
module tb_roll_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b0;
  logic       roll;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] rolls;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic roll_log [64];
  logic pp_log   [64];
  logic rp_log   [64];

  int rise, fall, npress, nrel, pedge, redge, nover, nhigh;

  roll_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .MIN_ROLL_CYCLES(8),
    .CNT_W(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_raw(btn_raw),
    .roll(roll),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .rolls(rolls)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called just after a posedge; bit e of pat is btn_raw as sampled by edge e.
  task automatic run_pattern(input logic [63:0] pat, input int n);
    for (int e = 0; e < n; e++) begin
      btn_raw = pat[e];
      @(posedge clock);
      #1;
      roll_log[e] = roll;
      pp_log[e]   = press_pulse;
      rp_log[e]   = release_pulse;
    end
    rise = -1; fall = -1; npress = 0; nrel = 0;
    pedge = -1; redge = -1; nover = 0; nhigh = 0;
    for (int e = 0; e < n; e++) begin
      if (roll_log[e]) nhigh++;
      if (roll_log[e] && rise < 0) rise = e;
      if (!roll_log[e] && rise >= 0 && fall < 0) fall = e;
      if (pp_log[e]) begin npress++; pedge = e; end
      if (rp_log[e]) begin nrel++; redge = e; end
      if (pp_log[e] && rp_log[e]) nover++;
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    btn_raw = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    // 1: button held through reset
    btn_raw = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("t1_reset_roll", int'(roll), 0);
    check("t1_reset_press", int'(press_pulse), 0);
    check("t1_reset_release", int'(release_pulse), 0);
    check("t1_reset_rolls", int'(rolls), 0);
    reset = 1'b0;
    run_pattern(64'h3FF, 30);
    check("t1_rise", rise, 6);
    check("t1_fall", fall, 16);
    check("t1_rolls", int'(rolls), 1);

    // 2: three-cycle glitch
    do_reset();
    run_pattern(64'h7, 20);
    check("t2_high_cycles", nhigh, 0);
    check("t2_press", npress, 0);
    check("t2_release", nrel, 0);
    check("t2_rolls", int'(rolls), 0);

    // 3: long press, edges 0-19
    do_reset();
    run_pattern(64'hF_FFFF, 40);
    check("t3_rise", rise, 6);
    check("t3_fall", fall, 26);
    check("t3_press_edge", pedge, 6);
    check("t3_release_edge", redge, 26);
    check("t3_press_cnt", npress, 1);
    check("t3_release_cnt", nrel, 1);
    check("t3_overlap", nover, 0);
    check("t3_rolls", int'(rolls), 1);

    // 4: short tap, minimum roll time enforced
    do_reset();
    run_pattern(64'h3F, 30);
    check("t4_rise", rise, 6);
    check("t4_fall", fall, 15);
    check("t4_press_cnt", npress, 1);
    check("t4_release_cnt", nrel, 1);
    check("t4_overlap", nover, 0);
    check("t4_rolls", int'(rolls), 1);

    // 6 (continues from tap above): reset asserted mid-roll
    run_pattern(64'hFF, 8);
    check("t6_roll_before", int'(roll), 1);
    reset = 1'b1;
    #1;
    check("t6_roll_async", int'(roll), 0);
    check("t6_rolls_async", int'(rolls), 0);
    check("t6_release_async", int'(release_pulse), 0);
    @(posedge clock);
    #1 btn_raw = 1'b0;
    reset = 1'b0;
    run_pattern(64'h0, 15);
    check("t6_after_high", nhigh, 0);
    check("t6_after_pulses", npress + nrel, 0);
    check("t6_after_rolls", int'(rolls), 0);

    // 5: release bounce (low 2, high 1, low steady)
    do_reset();
    run_pattern(64'h4F_FFFF, 40);
    check("t5_rise", rise, 6);
    check("t5_fall", fall, 29);
    check("t5_release_cnt", nrel, 1);
    check("t5_press_cnt", npress, 1);
    check("t5_rolls", int'(rolls), 1);

    // rolls counter wrap
    do_reset();
    for (int k = 0; k < 255; k++) run_pattern(64'h3F, 20);
    check("wrap_255", int'(rolls), 255);
    run_pattern(64'h3F, 20);
    check("wrap_pulse", nrel, 1);
    check("wrap_0", int'(rolls), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
